// File: rtl/tx_link_ctrl_ml_pkg.sv
// Shared JESD204B transmit link definitions: link state encoding and the
// per-lane link-layer mux codes consumed by the lane datapath.
package jesd_tx_pkg;

  typedef enum logic [1:0] {
    CGS       = 2'd0,
    WAIT_LMFC = 2'd1,
    ILAS      = 2'd2,
    DATA      = 2'd3
  } link_state_e;

  localparam logic [2:0] MUX_CGS        = 3'd0;
  localparam logic [2:0] MUX_ILAS_START = 3'd1;
  localparam logic [2:0] MUX_ILAS_END   = 3'd2;
  localparam logic [2:0] MUX_ILAS_CFG   = 3'd3;
  localparam logic [2:0] MUX_ILAS_DATA  = 3'd4;
  localparam logic [2:0] MUX_USER       = 3'd5;
  localparam logic [2:0] MUX_LANE_OFF   = 3'd6;

endpackage

// File: rtl/tx_link_ctrl_ml_sync_monitor.sv
// SYNC~ monitor: counts consecutive low frames, flags sync requests and
// detects short low pulses that the receiver uses as error reports.
module tx_sync_monitor #(
  parameter int SYNC_REQ_FRAMES = 5,
  parameter int ERR_CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_sync_n,
  input  logic                 i_err_window,
  input  logic                 i_req_clr,
  output logic                 o_sync_req_set,
  output logic                 o_sync_req,
  output logic                 o_req_seen,
  output logic                 o_err_report,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int LCW = $clog2(SYNC_REQ_FRAMES + 1);
  localparam logic [LCW-1:0] LOW_MAX = LCW'(SYNC_REQ_FRAMES);
  localparam logic [LCW-1:0] LOW_PRE = LCW'(SYNC_REQ_FRAMES - 1);

  logic [LCW-1:0]       low_cnt_q, low_cnt_d;
  logic                 sync_req_q, sync_req_d;
  logic                 req_seen_q, req_seen_d;
  logic                 err_report_q, err_report_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 req_set;
  logic                 err_hit;

  always_comb begin
    low_cnt_d = low_cnt_q;
    if (i_sync_n) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != LOW_MAX) begin
      low_cnt_d = low_cnt_q + LCW'(1);
    end
    // The request fires on the edge where the low run reaches its threshold.
    req_set    = !i_sync_n && (low_cnt_q == LOW_PRE);
    sync_req_d = i_sync_n ? 1'b0 : (sync_req_q | req_set);
    req_seen_d = req_set ? 1'b1 : (i_req_clr ? 1'b0 : req_seen_q);
    err_hit    = i_sync_n && (low_cnt_q != '0) && (low_cnt_q < LOW_MAX) && i_err_window;
    err_report_d = err_hit;
    err_cnt_d    = err_cnt_q;
    if (err_hit && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      low_cnt_q    <= '0;
      sync_req_q   <= 1'b0;
      req_seen_q   <= 1'b0;
      err_report_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      low_cnt_q    <= low_cnt_d;
      sync_req_q   <= sync_req_d;
      req_seen_q   <= req_seen_d;
      err_report_q <= err_report_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign o_sync_req_set = req_set;
  assign o_sync_req     = sync_req_q;
  assign o_req_seen     = req_seen_q;
  assign o_err_report   = err_report_q;
  assign o_err_cnt      = err_cnt_q;

endmodule

// File: rtl/tx_link_ctrl_ml.sv
// Multi-lane JESD204B transmit link controller: frame/LMFC counters, link
// bring-up sequencing (CGS, LMFC alignment, ILAS, DATA) and lane mux decode.
module tx_link_ctrl_ml
  import jesd_tx_pkg::*;
#(
  parameter int NUM_LANES       = 2,
  parameter int K_W             = 5,
  parameter int MF_W            = 8,
  parameter int SYNC_REQ_FRAMES = 5,
  parameter int ERR_CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_sync_n,
  input  logic [K_W-1:0]         i_K,
  input  logic [MF_W-1:0]        i_ila_mf,
  input  logic [NUM_LANES-1:0]   i_lane_en,
  output logic [3*NUM_LANES-1:0] o_link_mux,
  output logic [K_W-1:0]         o_frame_in_mf,
  output logic                   o_lmfc_tick,
  output logic                   o_link_up,
  output logic                   o_err_report,
  output logic [ERR_CNT_W-1:0]   o_err_cnt,
  output link_state_e            o_dbg_state
);

  link_state_e            state_q, state_d;
  logic [K_W-1:0]         fc_q, fc_d;
  logic [MF_W-1:0]        mfc_q, mfc_d;
  logic [3*NUM_LANES-1:0] link_mux_q, link_mux_d, rst_mux;
  logic                   link_up_q, link_up_d;
  logic [K_W-1:0]         keff;
  logic                   mf_end;
  logic                   req_clr;
  logic                   sync_req_set, sync_req, req_seen;
  logic [2:0]             lane_code;

  tx_sync_monitor #(
    .SYNC_REQ_FRAMES (SYNC_REQ_FRAMES),
    .ERR_CNT_W       (ERR_CNT_W)
  ) u_sync_mon (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_sync_n       (i_sync_n),
    .i_err_window   ((state_q == ILAS) || (state_q == DATA)),
    .i_req_clr      (req_clr),
    .o_sync_req_set (sync_req_set),
    .o_sync_req     (sync_req),
    .o_req_seen     (req_seen),
    .o_err_report   (o_err_report),
    .o_err_cnt      (o_err_cnt)
  );

  always_comb begin
    keff   = (i_K == '0) ? K_W'(1) : i_K;
    // Wrap on >= so a lowered K re-aligns on the very next frame.
    mf_end = (fc_q >= keff);
    fc_d   = mf_end ? '0 : fc_q + K_W'(1);

    state_d = state_q;
    mfc_d   = mfc_q;
    req_clr = 1'b0;
    if (sync_req_set) begin
      state_d = CGS;
      mfc_d   = '0;
    end else begin
      case (state_q)
        CGS: begin
          if (req_seen && !sync_req) begin
            state_d = WAIT_LMFC;
            req_clr = 1'b1;
          end
        end
        WAIT_LMFC: begin
          mfc_d = '0;
          if (mf_end) state_d = ILAS;
        end
        ILAS: begin
          if (mf_end) begin
            if (mfc_q == i_ila_mf) state_d = DATA;
            else                   mfc_d   = mfc_q + MF_W'(1);
          end
        end
        default: ;
      endcase
    end

    // Outputs are decoded from the next state so they register with it.
    case (state_d)
      ILAS: begin
        if (fc_d == keff)                        lane_code = MUX_ILAS_END;
        else if (fc_d == '0)                     lane_code = MUX_ILAS_START;
        else if (mfc_d == MF_W'(1) && fc_d == K_W'(1)) lane_code = MUX_ILAS_CFG;
        else                                     lane_code = MUX_ILAS_DATA;
      end
      DATA:    lane_code = MUX_USER;
      default: lane_code = MUX_CGS;
    endcase

    link_mux_d = '0;
    rst_mux    = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      link_mux_d[3*n +: 3] = i_lane_en[n] ? lane_code : MUX_LANE_OFF;
      rst_mux[3*n +: 3]    = i_lane_en[n] ? MUX_CGS : MUX_LANE_OFF;
    end
    link_up_d = (state_d == DATA);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CGS;
      fc_q       <= '0;
      mfc_q      <= '0;
      link_mux_q <= rst_mux;
      link_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fc_q       <= fc_d;
      mfc_q      <= mfc_d;
      link_mux_q <= link_mux_d;
      link_up_q  <= link_up_d;
    end
  end

  assign o_link_mux    = link_mux_q;
  assign o_frame_in_mf = fc_q;
  assign o_lmfc_tick   = (fc_q == '0);
  assign o_link_up     = link_up_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_tx_link_ctrl_ml.sv
// Self-checking bench for tx_link_ctrl_ml: reset, CGS idle, bring-up,
// error reporting, mid-ILAS resync, lane masking and K corner cases.
module tb_tx_link_ctrl_ml;
  import jesd_tx_pkg::*;

  localparam int NL = 4;
  localparam int KW = 5;
  localparam int MW = 8;
  localparam int EW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              sync_n;
  logic [KW-1:0]     k;
  logic [MW-1:0]     ila_mf;
  logic [NL-1:0]     lane_en;
  logic [3*NL-1:0]   link_mux;
  logic [KW-1:0]     frame_in_mf;
  logic              lmfc_tick;
  logic              link_up;
  logic              err_report;
  logic [EW-1:0]     err_cnt;
  link_state_e       dbg_state;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int exp_errs = 0;
  logic [3*NL-1:0] exp_q[$];
  logic [EW-1:0]   cnt_q[$];
  logic [2:0]      ila_codes [16];

  tx_link_ctrl_ml #(
    .NUM_LANES (NL), .K_W (KW), .MF_W (MW), .SYNC_REQ_FRAMES (5), .ERR_CNT_W (EW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .i_sync_n (sync_n), .i_K (k), .i_ila_mf (ila_mf),
    .i_lane_en (lane_en), .o_link_mux (link_mux), .o_frame_in_mf (frame_in_mf),
    .o_lmfc_tick (lmfc_tick), .o_link_up (link_up), .o_err_report (err_report),
    .o_err_cnt (err_cnt), .o_dbg_state (dbg_state)
  );

  function automatic logic [3*NL-1:0] mux_all(input logic [2:0] code, input logic [NL-1:0] en);
    logic [3*NL-1:0] r;
    for (int n = 0; n < NL; n++) r[3*n +: 3] = en[n] ? code : MUX_LANE_OFF;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sync_n = 1'b1; k = 5'd3; ila_mf = 8'd3; lane_en = '1;
    step(); step();
    exp_errs = 0;
    vec_cnt++; if (link_mux !== '0) begin miss_cnt++; $display("FAIL reset_mux got %h want %h", link_mux, 12'h0); end
    vec_cnt++; if (frame_in_mf !== 5'd0) begin miss_cnt++; $display("FAIL reset_fc got %0d want 0", frame_in_mf); end
    vec_cnt++; if (lmfc_tick !== 1'b1) begin miss_cnt++; $display("FAIL reset_tick got %b want 1", lmfc_tick); end
    vec_cnt++; if (link_up !== 1'b0) begin miss_cnt++; $display("FAIL reset_link_up got %b want 0", link_up); end
    vec_cnt++; if (err_report !== 1'b0) begin miss_cnt++; $display("FAIL reset_err_report got %b want 0", err_report); end
    vec_cnt++; if (err_cnt !== 8'd0) begin miss_cnt++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    vec_cnt++; if (dbg_state !== CGS) begin miss_cnt++; $display("FAIL reset_state got %0d want 0", dbg_state); end
  endtask

  task automatic test_cgs_idle();
    int exp_fc;
    exp_fc = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      exp_fc = (exp_fc == 3) ? 0 : exp_fc + 1;
      vec_cnt++; if (frame_in_mf !== KW'(exp_fc)) begin miss_cnt++; $display("FAIL idle_fc got %0d want %0d", frame_in_mf, exp_fc); end
      vec_cnt++; if (lmfc_tick !== (exp_fc == 0)) begin miss_cnt++; $display("FAIL idle_tick got %b want %b", lmfc_tick, exp_fc == 0); end
      vec_cnt++; if (link_mux !== '0) begin miss_cnt++; $display("FAIL idle_mux got %h want 0", link_mux); end
      vec_cnt++; if (dbg_state !== CGS) begin miss_cnt++; $display("FAIL idle_state got %0d want 0", dbg_state); end
    end
  endtask

  task automatic drive_sync_req();
    sync_n = 1'b0;
    repeat (6) step();
    sync_n = 1'b1;
  endtask

  task automatic wait_ilas(input logic [NL-1:0] en, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (link_mux !== mux_all(MUX_CGS, en)) begin ok = 1'b1; break; end
    end
    vec_cnt++; if (!ok) begin miss_cnt++; $display("FAIL ilas_start_timeout got %h want ILAS start within 20 cycles", link_mux); end
    if (ok) begin
      vec_cnt++; if (frame_in_mf !== 5'd0) begin miss_cnt++; $display("FAIL ilas_start_fc got %0d want 0", frame_in_mf); end
    end
  endtask

  // ILAS from its first cycle through to DATA; the bring-up stimulus is already applied.
  task automatic check_ilas(input logic [NL-1:0] en);
    bit ok;
    logic [3*NL-1:0] exp;
    for (int i = 0; i < 16; i++) exp_q.push_back(mux_all(ila_codes[i], en));
    wait_ilas(en, ok);
    if (!ok) exp_q.delete();
    while (exp_q.size() > 0) begin
      if (exp_q.size() < 16) step();
      exp = exp_q.pop_front();
      vec_cnt++; if (link_mux !== exp) begin miss_cnt++; $display("FAIL ilas_code got %h want %h", link_mux, exp); end
      vec_cnt++; if (link_up !== 1'b0) begin miss_cnt++; $display("FAIL ilas_link_up got %b want 0", link_up); end
    end
    step();
    vec_cnt++; if (link_up !== 1'b1) begin miss_cnt++; $display("FAIL data_link_up got %b want 1", link_up); end
    vec_cnt++; if (link_mux !== mux_all(MUX_USER, en)) begin miss_cnt++; $display("FAIL data_mux got %h want %h", link_mux, mux_all(MUX_USER, en)); end
  endtask

  task automatic bring_up(input logic [NL-1:0] en);
    lane_en = en;
    drive_sync_req();
    check_ilas(en);
  endtask

  task automatic test_err_report();
    logic [EW-1:0] exp;
    for (int r = 0; r < 300; r++) begin
      sync_n = 1'b0;
      step(); step();
      sync_n = 1'b1;
      exp_errs = (exp_errs == 255) ? 255 : exp_errs + 1;
      cnt_q.push_back(EW'(exp_errs));
      step();
      exp = cnt_q.pop_front();
      vec_cnt++; if (err_report !== 1'b1) begin miss_cnt++; $display("FAIL err_pulse got %b want 1", err_report); end
      vec_cnt++; if (err_cnt !== exp) begin miss_cnt++; $display("FAIL err_cnt got %0d want %0d", err_cnt, exp); end
      vec_cnt++; if (link_up !== 1'b1) begin miss_cnt++; $display("FAIL err_link_up got %b want 1", link_up); end
      step();
      vec_cnt++; if (err_report !== 1'b0) begin miss_cnt++; $display("FAIL err_pulse_end got %b want 0", err_report); end
    end
    vec_cnt++; if (err_cnt !== 8'd255) begin miss_cnt++; $display("FAIL err_cnt_sat got %0d want 255", err_cnt); end
  endtask

  task automatic test_ila_resync();
    bit ok;
    lane_en = '1;
    drive_sync_req();
    wait_ilas(lane_en, ok);
    if (ok) begin
      for (int i = 1; i <= 4; i++) begin
        step();
        vec_cnt++; if (link_mux !== mux_all(ila_codes[i], lane_en)) begin miss_cnt++; $display("FAIL resync_pre got %h want %h", link_mux, mux_all(ila_codes[i], lane_en)); end
      end
      sync_n = 1'b0;
      for (int j = 1; j <= 4; j++) begin
        step();
        vec_cnt++; if (link_mux !== mux_all(ila_codes[4 + j], lane_en)) begin miss_cnt++; $display("FAIL resync_hold got %h want %h", link_mux, mux_all(ila_codes[4 + j], lane_en)); end
      end
      step();
      vec_cnt++; if (dbg_state !== CGS) begin miss_cnt++; $display("FAIL resync_state got %0d want 0", dbg_state); end
      vec_cnt++; if (link_mux !== mux_all(MUX_CGS, lane_en)) begin miss_cnt++; $display("FAIL resync_mux got %h want 0", link_mux); end
      sync_n = 1'b1;
      for (int j = 0; j < 2; j++) begin
        step();
        vec_cnt++; if (err_report !== 1'b0) begin miss_cnt++; $display("FAIL resync_no_err got %b want 0", err_report); end
      end
      vec_cnt++; if (err_cnt !== EW'(exp_errs)) begin miss_cnt++; $display("FAIL resync_err_cnt got %0d want %0d", err_cnt, exp_errs); end
      check_ilas(lane_en);
    end else begin
      sync_n = 1'b1;
    end
  endtask

  task automatic test_k_corner();
    int exp_fc;
    lane_en = '1; sync_n = 1'b1; k = 5'd0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    exp_errs = 0;
    exp_fc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_fc = (exp_fc >= 1) ? 0 : 1;
      vec_cnt++; if (frame_in_mf !== KW'(exp_fc)) begin miss_cnt++; $display("FAIL k0_fc got %0d want %0d", frame_in_mf, exp_fc); end
    end
    k = 5'd7;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    repeat (5) step();
    vec_cnt++; if (frame_in_mf !== 5'd5) begin miss_cnt++; $display("FAIL k7_fc got %0d want 5", frame_in_mf); end
    k = 5'd2;
    exp_fc = 5;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_fc = (exp_fc >= 2) ? 0 : exp_fc + 1;
      vec_cnt++; if (frame_in_mf !== KW'(exp_fc)) begin miss_cnt++; $display("FAIL kdrop_fc got %0d want %0d", frame_in_mf, exp_fc); end
    end
  endtask

  task automatic test_reset_mid_data();
    k = 5'd3;
    bring_up('1);
    sync_n = 1'b0; step(); step(); sync_n = 1'b1;
    step();
    vec_cnt++; if (err_cnt !== 8'd1) begin miss_cnt++; $display("FAIL mid_err_cnt got %0d want 1", err_cnt); end
    step();
    rst_n = 1'b0;
    step();
    vec_cnt++; if (link_mux !== '0) begin miss_cnt++; $display("FAIL mid_rst_mux got %h want 0", link_mux); end
    vec_cnt++; if (frame_in_mf !== 5'd0) begin miss_cnt++; $display("FAIL mid_rst_fc got %0d want 0", frame_in_mf); end
    vec_cnt++; if (lmfc_tick !== 1'b1) begin miss_cnt++; $display("FAIL mid_rst_tick got %b want 1", lmfc_tick); end
    vec_cnt++; if (link_up !== 1'b0) begin miss_cnt++; $display("FAIL mid_rst_link_up got %b want 0", link_up); end
    vec_cnt++; if (err_report !== 1'b0) begin miss_cnt++; $display("FAIL mid_rst_err_report got %b want 0", err_report); end
    vec_cnt++; if (err_cnt !== 8'd0) begin miss_cnt++; $display("FAIL mid_rst_err_cnt got %0d want 0", err_cnt); end
    vec_cnt++; if (dbg_state !== CGS) begin miss_cnt++; $display("FAIL mid_rst_state got %0d want 0", dbg_state); end
    rst_n = 1'b1;
  endtask

  initial begin
    ila_codes = '{3'd1, 3'd4, 3'd4, 3'd2,
                  3'd1, 3'd3, 3'd4, 3'd2,
                  3'd1, 3'd4, 3'd4, 3'd2,
                  3'd1, 3'd4, 3'd4, 3'd2};
    test_reset();
    test_cgs_idle();
    bring_up('1);
    test_err_report();
    test_ila_resync();
    bring_up(4'b1010);
    test_k_corner();
    test_reset_mid_data();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
